// File: rtl/cpu_status_display_pkg.sv
// -----------------------------------------------------------------------------
// cpu_status_display_pkg
// Shared constants and types for the CPU status display block:
//   - CPU mode encodings driven by cpu_control
//   - active-low seven-segment patterns for blank and dash
//   - read/display FSM state type
//   - helper that tells whether the CPU is in a running mode (run/debug)
// -----------------------------------------------------------------------------
package cpu_status_display_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_PROG  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_DEBUG = 2'b11;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SHOW
  } state_t;

  // Run and debug are the modes in which the program-running flag means something.
  function automatic logic mode_active(input logic [1:0] mode);
    return (mode == MODE_RUN) || (mode == MODE_DEBUG);
  endfunction

endpackage

// File: rtl/cpu_status_display_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational 4-bit to active-low seven-segment decoder.
// Ports:
//   nibble_i  in  4  hex digit to show
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex_to_7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/cpu_status_display.sv
// -----------------------------------------------------------------------------
// cpu_status_display
// Drives the DE2 HEX/LED indicators from the routed CPU control outputs.
// Periodically (and on every address change) reads the selected register over
// a req/valid port, holds the value and shows it on four hex digits, with the
// register address on two more digits.
//
// Ports:
//   clk             in   1   system clock
//   resetn          in   1   asynchronous active-low reset
//   cpumode         in   2   00 idle, 01 program, 10 run, 11 debug
//   addressdisplay  in   6   register address to display
//   runprog         in   1   program running (1) / paused (0)
//   rf_rd_req       out  1   one-cycle read request
//   rf_rd_addr      out  6   read address, stable while waiting
//   rf_rd_valid     in   1   read data valid (one cycle)
//   rf_rd_data      in   16  read data
//   hex0..hex3      out  7   value digits, nibble 0..3, active-low
//   hex4, hex5      out  7   address digits (low nibble, high two bits)
//   ledg            out  4   {sticky read error, run indicator, cpumode}
//
// Build option: define PAUSE_BLINK_EN to make the run indicator blink with a
// half-period of BLINK_DIV cycles while the CPU is paused in run/debug mode.
// -----------------------------------------------------------------------------
module cpu_status_display
  import cpu_status_display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int BLINK_DIV      = 12500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  cpumode,
  input  logic [5:0]  addressdisplay,
  input  logic        runprog,
  output logic        rf_rd_req,
  output logic [5:0]  rf_rd_addr,
  input  logic        rf_rd_valid,
  input  logic [15:0] rf_rd_data,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [3:0]  ledg
);

  localparam int RCW = $clog2(REFRESH_CYCLES);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [RCW-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [TCW-1:0]  timeout_cnt_q, timeout_cnt_d;
  logic [5:0]      addr_prev_q;
  logic            addr_seen_q;
  logic            addr_pend_q, addr_pend_d;
  logic [5:0]      rd_addr_q, rd_addr_d;
  logic [15:0]     held_q, held_d;
  logic            dash_q, dash_d;
  logic            err_q, err_d;
  logic [1:0]      mode_q;
  logic            run_led_q;
  logic [6:0]      hex_q [6];

  logic            mode_off;
  logic            addr_chg;
  logic            start_read;
  logic            in_wait;
  logic            capture;
  logic            timeout_hit;
  logic            load_disp;

  // addr_seen_q masks the first cycle after reset, when addr_prev_q has not
  // yet sampled the switches; otherwise reset itself would look like a change.
  assign mode_off    = (cpumode == MODE_IDLE);
  assign addr_chg    = addr_seen_q && (addressdisplay != addr_prev_q);
  assign start_read  = addr_chg || addr_pend_q || (refresh_cnt_q == REFRESH_LAST);
  assign in_wait     = (state_q == ST_WAIT) && !mode_off;
  assign capture     = in_wait && rf_rd_valid;
  assign timeout_hit = in_wait && !rf_rd_valid && (timeout_cnt_q == TIMEOUT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (mode_off) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_read) state_d = ST_REQ;
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (rf_rd_valid)      state_d = ST_SHOW;
          else if (timeout_hit) state_d = ST_IDLE;
        end
        ST_SHOW: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_rd_req = (state_q == ST_REQ);
    // A timeout refreshes the display directly (dashes) without visiting SHOW.
    load_disp = (state_q == ST_SHOW) || timeout_hit;
  end

  assign rf_rd_addr = rd_addr_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    addr_pend_d   = addr_pend_q;
    rd_addr_d     = rd_addr_q;
    held_d        = held_q;
    dash_d        = dash_q;
    err_d         = err_q;

    if (mode_off) begin
      refresh_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      refresh_cnt_d = start_read ? '0 : refresh_cnt_q + RCW'(1);
    end

    // A change seen while a read is in flight is remembered and replayed from
    // IDLE; in IDLE the change itself launches the read.
    if (mode_off || (state_q == ST_IDLE)) begin
      addr_pend_d = 1'b0;
    end else if (addr_chg) begin
      addr_pend_d = 1'b1;
    end

    if ((state_q == ST_IDLE) && !mode_off && start_read) begin
      rd_addr_d = addressdisplay;
    end

    if (state_q == ST_REQ) begin
      timeout_cnt_d = '0;
    end else if (in_wait && !rf_rd_valid && !timeout_hit) begin
      timeout_cnt_d = timeout_cnt_q + TCW'(1);
    end

    if (capture) begin
      held_d = rf_rd_data;
      dash_d = 1'b0;
    end else if (timeout_hit) begin
      dash_d = 1'b1;
    end

    if (mode_off || capture) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      refresh_cnt_q <= '0;
      timeout_cnt_q <= '0;
      addr_prev_q   <= '0;
      addr_seen_q   <= 1'b0;
      addr_pend_q   <= 1'b0;
      rd_addr_q     <= '0;
      held_q        <= '0;
      dash_q        <= 1'b0;
      err_q         <= 1'b0;
      mode_q        <= MODE_IDLE;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      addr_prev_q   <= addressdisplay;
      addr_seen_q   <= 1'b1;
      addr_pend_q   <= addr_pend_d;
      rd_addr_q     <= rd_addr_d;
      held_q        <= held_d;
      dash_q        <= dash_d;
      err_q         <= err_d;
      mode_q        <= cpumode;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode. Value digits decode the next held value so a timeout can
  // load dashes in the same edge that raises the error.
  // ---------------------------------------------------------------------------
  logic [3:0] nib      [6];
  logic [6:0] seg_dec  [6];
  logic [6:0] seg_next [6];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_value_digit
      assign nib[gi]      = held_d[4*gi +: 4];
      assign seg_next[gi] = dash_d ? SEG_DASH : seg_dec[gi];
    end
    for (gi = 0; gi < 6; gi++) begin : g_decoder
      hex_to_7seg u_dec (
        .nibble_i (nib[gi]),
        .seg_o    (seg_dec[gi])
      );
    end
  endgenerate

  assign nib[4]      = rd_addr_q[3:0];
  assign nib[5]      = {2'b00, rd_addr_q[5:4]};
  assign seg_next[4] = seg_dec[4];
  assign seg_next[5] = seg_dec[5];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else if (mode_off) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else if (load_disp) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= seg_next[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

  // ---------------------------------------------------------------------------
  // Run indicator
  // ---------------------------------------------------------------------------
`ifdef PAUSE_BLINK_EN
  localparam int BCW = $clog2(BLINK_DIV + 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  logic           pause_now;
  logic           pause_q;
  logic [BCW-1:0] blink_cnt_q;

  assign pause_now = mode_active(cpumode) && !runprog;

  // Every entry into pause restarts the blink phase dark.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pause_q     <= 1'b0;
      blink_cnt_q <= '0;
      run_led_q   <= 1'b0;
    end else begin
      pause_q <= pause_now;
      if (!pause_now) begin
        blink_cnt_q <= '0;
        run_led_q   <= mode_active(cpumode) && runprog;
      end else if (!pause_q) begin
        blink_cnt_q <= '0;
        run_led_q   <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        run_led_q   <= ~run_led_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BCW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_led_q <= 1'b0;
    end else begin
      run_led_q <= mode_active(cpumode) && runprog;
    end
  end
`endif

  assign ledg = {err_q, run_led_q, mode_q};

endmodule

// File: tb/tb_cpu_status_display.sv
// -----------------------------------------------------------------------------
// tb_cpu_status_display
// Directed self-checking bench for cpu_status_display with REFRESH_CYCLES=8,
// TIMEOUT_CYCLES=4, BLINK_DIV=4. The bench plays the register file by hand.
// -----------------------------------------------------------------------------
module tb_cpu_status_display;

  logic        clk;
  logic        resetn;
  logic [1:0]  cpumode;
  logic [5:0]  addressdisplay;
  logic        runprog;
  logic        rf_rd_req;
  logic [5:0]  rf_rd_addr;
  logic        rf_rd_valid;
  logic [15:0] rf_rd_data;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [3:0]  ledg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_req = 0;

  // Active-low segment patterns for 0..F, {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [16];
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  cpu_status_display #(
    .REFRESH_CYCLES (8),
    .TIMEOUT_CYCLES (4),
    .BLINK_DIV      (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cpumode        (cpumode),
    .addressdisplay (addressdisplay),
    .runprog        (runprog),
    .rf_rd_req      (rf_rd_req),
    .rf_rd_addr     (rf_rd_addr),
    .rf_rd_valid    (rf_rd_valid),
    .rf_rd_data     (rf_rd_data),
    .hex0           (hex0),
    .hex1           (hex1),
    .hex2           (hex2),
    .hex3           (hex3),
    .hex4           (hex4),
    .hex5           (hex5),
    .ledg           (ledg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait up to max_cycles for a read request; n is the number of edges taken.
  task automatic wait_req(input int max_cycles, output int n);
    n = 0;
    while (n < max_cycles) begin
      tick();
      n++;
      if (rf_rd_req) break;
    end
    check("req_seen", 32'(rf_rd_req), 32'd1);
    $display("read request addr=%02h after %0d cycles (cycle %0d)", rf_rd_addr, n, cyc);
  endtask

  // Called just after the request edge: valid two cycles after req, then
  // one cycle to SHOW and one to load the digits.
  task automatic respond(input logic [15:0] d);
    tick();
    tick();
    rf_rd_valid = 1'b1;
    rf_rd_data  = d;
    tick();
    rf_rd_valid = 1'b0;
    rf_rd_data  = 16'h0000;
    tick();
    $display("read response data=%04h", d);
  endtask

  task automatic check_disp(input logic [15:0] v, input logic [5:0] a);
    logic [3:0] hi;
    hi = {2'b00, a[5:4]};
    check("hex0", 32'(hex0), 32'(seg_tab[v[3:0]]));
    check("hex1", 32'(hex1), 32'(seg_tab[v[7:4]]));
    check("hex2", 32'(hex2), 32'(seg_tab[v[11:8]]));
    check("hex3", 32'(hex3), 32'(seg_tab[v[15:12]]));
    check("hex4", 32'(hex4), 32'(seg_tab[a[3:0]]));
    check("hex5", 32'(hex5), 32'(seg_tab[hi]));
    $display("display check value=%04h addr=%02h", v, a);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_hex0"}, 32'(hex0), 32'(BLANK));
    check({tag, "_hex1"}, 32'(hex1), 32'(BLANK));
    check({tag, "_hex2"}, 32'(hex2), 32'(BLANK));
    check({tag, "_hex3"}, 32'(hex3), 32'(BLANK));
    check({tag, "_hex4"}, 32'(hex4), 32'(BLANK));
    check({tag, "_hex5"}, 32'(hex5), 32'(BLANK));
  endtask

  initial begin
    int n;
    int reqs;
    logic exp_led;

    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    resetn         = 1'b0;
    cpumode        = 2'b10;
    addressdisplay = 6'h05;
    runprog        = 1'b1;
    rf_rd_valid    = 1'b0;
    rf_rd_data     = 16'h0000;

    // ---- reset state
    tick();
    tick();
    check_blank("reset");
    check("reset_ledg", 32'(ledg), 32'h0);
    check("reset_req", 32'(rf_rd_req), 32'h0);
    check("reset_addr", 32'(rf_rd_addr), 32'h0);
    $display("reset applied");

    // ---- first read after release only when refresh expires
    resetn = 1'b1;
    wait_req(20, n);
    check("first_req_delay", 32'(n), 32'd8);
    check("run_ledg", 32'(ledg), 32'h6);
    check("rd_addr_05", 32'(rf_rd_addr), 32'h05);
    last_req = cyc;
    respond(16'hBEEF);
    check_disp(16'hBEEF, 6'h05);

    // ---- periodic refresh: 8 idle + 1 req + 2 wait + 1 show
    wait_req(20, n);
    check("refresh_period", 32'(cyc - last_req), 32'd12);
    respond(16'h1234);
    check_disp(16'h1234, 6'h05);

    // ---- address change forces a request on the next edge
    addressdisplay = 6'h12;
    wait_req(2, n);
    check("addr_change_latency", 32'(n), 32'd1);
    check("rd_addr_12", 32'(rf_rd_addr), 32'h12);
    respond(16'hA5C0);
    check_disp(16'hA5C0, 6'h12);

    // ---- timeout after exactly 4 WAIT cycles
    wait_req(20, n);
    repeat (4) tick();
    check("err_before_timeout", 32'(ledg[3]), 32'd0);
    check("hex0_before_timeout", 32'(hex0), 32'(seg_tab[0]));
    tick();
    check("timeout_hex0", 32'(hex0), 32'(DASH));
    check("timeout_hex1", 32'(hex1), 32'(DASH));
    check("timeout_hex2", 32'(hex2), 32'(DASH));
    check("timeout_hex3", 32'(hex3), 32'(DASH));
    check("timeout_hex4", 32'(hex4), 32'(seg_tab[2]));
    check("timeout_err", 32'(ledg[3]), 32'd1);
    $display("read timeout observed");
    // late valid while idle is ignored
    rf_rd_valid = 1'b1;
    rf_rd_data  = 16'hFFFF;
    tick();
    rf_rd_valid = 1'b0;
    tick();
    check("late_valid_ignored", 32'(hex0), 32'(DASH));
    check("err_sticky", 32'(ledg[3]), 32'd1);
    // next good read clears the error
    wait_req(20, n);
    respond(16'h0001);
    check_disp(16'h0001, 6'h12);
    check("err_cleared", 32'(ledg[3]), 32'd0);

    // ---- address change during WAIT is replayed after the read completes
    wait_req(20, n);
    tick();
    addressdisplay = 6'h3F;
    tick();
    rf_rd_valid = 1'b1;
    rf_rd_data  = 16'h0F0F;
    tick();
    rf_rd_valid = 1'b0;
    tick();
    check_disp(16'h0F0F, 6'h12);
    tick();
    check("pending_req", 32'(rf_rd_req), 32'd1);
    check("rd_addr_3f", 32'(rf_rd_addr), 32'h3F);
    $display("replayed read request addr=%02h", rf_rd_addr);

    // ---- mode 00 during WAIT
    tick();
    cpumode = 2'b00;
    tick();
    check_blank("mode00");
    check("mode00_ledg", 32'(ledg), 32'h0);
    check("mode00_req", 32'(rf_rd_req), 32'd0);
    rf_rd_valid = 1'b1;
    rf_rd_data  = 16'h1111;
    tick();
    rf_rd_valid = 1'b0;
    reqs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rf_rd_req) reqs++;
    end
    check("mode00_no_req", 32'(reqs), 32'd0);
    check("mode00_hex0", 32'(hex0), 32'(BLANK));
    $display("mode 00 idle check done");

    // ---- run indicator by mode
    cpumode = 2'b11;
    runprog = 1'b1;
    tick();
    check("debug_ledg", 32'(ledg), 32'h7);
    cpumode = 2'b01;
    tick();
    check("prog_ledg", 32'(ledg), 32'h1);
    $display("run indicator checks done");

    // ---- pause in run mode
    cpumode = 2'b10;
    runprog = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
`ifdef PAUSE_BLINK_EN
      exp_led = ((k / 4) % 2) == 1;
`else
      exp_led = 1'b0;
`endif
      check($sformatf("pause_led_%0d", k), 32'(ledg[2]), 32'(exp_led));
    end
    $display("pause indicator checks done");

    // ---- asynchronous reset mid-WAIT
    runprog = 1'b1;
    wait_req(30, n);
    tick();
    resetn = 1'b0;
    #1;
    check_blank("async_reset");
    check("async_reset_ledg", 32'(ledg), 32'h0);
    check("async_reset_req", 32'(rf_rd_req), 32'd0);
    check("async_reset_addr", 32'(rf_rd_addr), 32'h0);
    tick();
    resetn = 1'b1;
    wait_req(20, n);
    check("post_reset_req_delay", 32'(n), 32'd8);
    $display("reset mid-read done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_status_display.md
Name: cpu_status_display

Overview:
- Output-side counterpart of the switch/key input router: takes the routed CPU control outputs (mode, display address, run flag) and drives the board HEX/LED indicators.
- Periodically reads the register at the selected address over a req/valid read port into the register file.
- Holds the value and shows it as four hex digits, with the address on two more digits.
- Sits between cpu_control/register file and the DE2 seven-segment and LED pins.

Parameters:
- REFRESH_CYCLES, 50000, clk cycles between periodic register re-reads (>=2).
- TIMEOUT_CYCLES, 16, cycles to wait for rf_rd_valid before declaring a read failure (>=1).
- BLINK_DIV, 12500000, half-period in cycles of the pause-blink indicator (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cpumode  in  2  00 idle, 01 program, 10 run, 11 debug
- addressdisplay  in  6  register address to display
- runprog  in  1  program running (1) / paused (0)
- rf_rd_req  out  1  read request to register file, one-cycle pulse
- rf_rd_addr  out  6  read address; valid while waiting
- rf_rd_valid  in  1  read data valid, one cycle
- rf_rd_data  in  16  read data
- hex0..hex3  out  7 each  value digits, nibble 0..3; active-low, bit6 = segment g
- hex4, hex5  out  7 each  address digits: low nibble, and high two bits zero-extended
- ledg  out  4  [1:0] = cpumode, [2] = run indicator, [3] = sticky read error

Behaviour:
- Reset (asynchronous, resetn=0):
  - hex0..hex5 = 7'h7F (blank).
  - ledg = 0, rf_rd_req = 0, rf_rd_addr = 0.
  - Held value = 0, refresh counter = 0, FSM = IDLE.
- FSM states: IDLE, REQ, WAIT, SHOW.
- IDLE:
  - Refresh counter increments each cycle while cpumode != 00.
  - On count = REFRESH_CYCLES-1, or on any change of addressdisplay (compared against a registered copy): go to REQ and clear the counter.
  - An address change wins over a refresh expiring in the same cycle; only one read is issued.
- REQ (1 cycle):
  - rf_rd_req = 1, rf_rd_addr = latched addressdisplay; go to WAIT.
  - Timeout counter cleared.
- WAIT:
  - rf_rd_valid = 1: capture rf_rd_data; go to SHOW.
  - Otherwise count; at TIMEOUT_CYCLES with no valid: held value replaced by "dashes" flag, ledg[3] set, go to IDLE.
  - An address change during WAIT does not abort the read. The change is registered and triggers a new read after returning to IDLE.
- SHOW (1 cycle): update hex0..hex5 from held value and latched address; return to IDLE.
  - Display latency: valid cycle + 1 register stage.
- rf_rd_valid arriving outside WAIT is ignored.
- Hex encoding: standard active-low 0-F, e.g. 0 = 7'b1000000, F = 7'b0001110. Dash = 7'b0111111.
- cpumode = 00:
  - FSM forced to IDLE next cycle, even mid-WAIT.
  - Counter held at 0, hex0..hex5 blank, ledg[2] = 0.
  - ledg[3] cleared.
- ledg[3] (sticky error): cleared by reset, by entering mode 00, or by the next successful read.
- ledg[1:0] = cpumode, registered (1-cycle lag).
- ledg[2] = runprog when cpumode is 10 or 11, else 0.

Optional Feature:
- Macro PAUSE_BLINK_EN.
- Defined: when cpumode is 10 or 11 and runprog = 0, ledg[2] toggles every BLINK_DIV cycles. The blink counter resets to 0 and ledg[2] goes to 0 on each entry into pause.
- Undefined: ledg[2] follows the rule in Behaviour; BLINK_DIV is unused and no blink counter is synthesized.

Decomposition:
- Shared package holds:
  - CPU mode constants MODE_IDLE/PROG/RUN/DEBUG (2'b00..2'b11).
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'b0111111.
  - The FSM state typedef.
- One sub-module, hex_to_7seg: combinational 4-bit to active-low segment decoder, instantiated six times.

Test Plan:
- Reset: resetn low mid-WAIT → all hex = 7'h7F, ledg = 0, rf_rd_req = 0 immediately, no request after release until refresh expires.
- Run mode, address 6'h05, register file returns 16'hBEEF two cycles after req → rf_rd_addr = 05; hex3..0 = B,E,E,F and hex5,hex4 = 0,5 one cycle after valid.
- REFRESH_CYCLES = 8, static address → rf_rd_req pulses every 8 + read-latency + 2 cycles. Address change to 6'h12 forces a request within 2 cycles.
- rf_rd_valid never asserted, TIMEOUT_CYCLES = 4 → after 4 WAIT cycles hex0..3 = dash, ledg[3] = 1. A subsequent good read of 16'h0001 clears ledg[3] and shows 0001.
- Switch cpumode 10 → 00 during WAIT → FSM to IDLE, late rf_rd_valid ignored, hex blank, ledg = 0 after 1 cycle.
- With PAUSE_BLINK_EN, BLINK_DIV = 4, run mode, runprog = 0 → ledg[2] toggles every 4 cycles starting at 0. Without the macro, ledg[2] stays 0.
